// File: rtl/cpu_pkg.sv
// cpu_pkg: shared datapath widths, load-size encodings and register constants.
package cpu_pkg;
    localparam int DATA_W_DEFAULT = 32;
    localparam int REG_AW_DEFAULT = 5;
    localparam logic [1:0] LS_WORD = 2'b00;
    localparam logic [1:0] LS_HALF = 2'b01;
    localparam logic [1:0] LS_BYTE = 2'b10;
    localparam logic [4:0] REG_ZERO = 5'd0;
endpackage

// File: rtl/load_formatter.sv
// load_formatter: extracts a little-endian byte/halfword lane from an aligned
// memory word and sign- or zero-extends it; words pass through unchanged.
// Ports: data (raw word), offset (byte offset), size (LS_* code, 11 = word),
//        zero_ext (zero-extend sub-word results), result (formatted word).
module load_formatter
    import cpu_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEFAULT
) (
    input  logic [DATA_W-1:0] data,
    input  logic [1:0]        offset,
    input  logic [1:0]        size,
    input  logic              zero_ext,
    output logic [DATA_W-1:0] result
);
    logic [7:0]  byte_lane;
    logic [15:0] half_lane;
    always_comb begin
        byte_lane = data[{offset, 3'b000} +: 8];
        // Halfword lane ignores offset[0]: misaligned halves are not trapped.
        half_lane = offset[1] ? data[31:16] : data[15:0];
        result    = size == LS_BYTE ? {{(DATA_W-8){~zero_ext & byte_lane[7]}}, byte_lane}
                  : size == LS_HALF ? {{(DATA_W-16){~zero_ext & half_lane[15]}}, half_lane}
                  : data;
    end
endmodule

// File: rtl/writeback_unit.sv
// writeback_unit: final pipeline stage. Holds the MEM/WB register, selects the
// write-back value, drives the register-file write port, a one-cycle-delayed
// bypass copy of that port, and a retired-instruction counter.
// Build option: define WB_LOAD_FORMAT_EN to enable sub-word load formatting;
// otherwise load data is written back as the full word.
// Ports:
//   clk, reset (async, active-high)
//   stall_in / flush_in            : hold / bubble the MEM/WB register
//   mem_*                          : MEM-stage instruction fields
//   reg_write, reg_wr_addr_wb, reg_wr_data : register-file write port
//   fwd_valid, fwd_addr, fwd_data  : previous cycle's write port
//   retired_count                  : instructions retired (wraps)
module writeback_unit
    import cpu_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEFAULT,
    parameter int REG_AW = REG_AW_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall_in,
    input  logic              flush_in,
    input  logic              mem_valid,
    input  logic              mem_reg_write,
    input  logic              mem_to_reg,
    input  logic              mem_link,
    input  logic [REG_AW-1:0] mem_rd,
    input  logic [DATA_W-1:0] mem_alu_result,
    input  logic [DATA_W-1:0] mem_load_data,
    input  logic [DATA_W-1:0] mem_pc_plus8,
    input  logic [1:0]        mem_load_size,
    input  logic              mem_load_unsigned,
    output logic              reg_write,
    output logic [REG_AW-1:0] reg_wr_addr_wb,
    output logic [DATA_W-1:0] reg_wr_data,
    output logic              fwd_valid,
    output logic [REG_AW-1:0] fwd_addr,
    output logic [DATA_W-1:0] fwd_data,
    output logic [31:0]       retired_count
);
    logic [DATA_W-1:0] load_value;
    logic [DATA_W-1:0] wr_value;
    logic              wb_valid;
    logic              wb_reg_write;
    logic              wb_fresh;
    logic [REG_AW-1:0] wb_rd;
    logic [DATA_W-1:0] wb_data;

`ifdef WB_LOAD_FORMAT_EN
    load_formatter #(.DATA_W(DATA_W)) u_load_formatter (
        .data     (mem_load_data),
        .offset   (mem_alu_result[1:0]),
        .size     (mem_load_size),
        .zero_ext (mem_load_unsigned),
        .result   (load_value)
    );
`else
    logic unused_load_cfg;
    assign unused_load_cfg = ^{mem_load_size, mem_load_unsigned};
    assign load_value = mem_load_data;
`endif

    // Link beats load beats ALU.
    always_comb wr_value = mem_link ? mem_pc_plus8 : mem_to_reg ? load_value : mem_alu_result;

    // wb_fresh marks the first WB cycle so a stalled instruction writes once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wb_valid      <= 1'b0;
            wb_reg_write  <= 1'b0;
            wb_fresh      <= 1'b0;
            wb_rd         <= '0;
            wb_data       <= '0;
            retired_count <= '0;
        end else if (flush_in) begin
            wb_valid <= 1'b0;
            wb_fresh <= 1'b0;
        end else if (stall_in) begin
            wb_fresh <= 1'b0;
        end else begin
            wb_valid      <= mem_valid;
            wb_reg_write  <= mem_reg_write;
            wb_fresh      <= 1'b1;
            wb_rd         <= mem_rd;
            wb_data       <= wr_value;
            retired_count <= retired_count + {31'd0, mem_valid};
        end
    end

    assign reg_write      = wb_valid & wb_fresh & wb_reg_write & (wb_rd != REG_AW'(REG_ZERO));
    assign reg_wr_addr_wb = wb_rd;
    assign reg_wr_data    = wb_data;

    // Bypass copy lets decode see a write landing on the same edge as its read.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fwd_valid <= 1'b0;
            fwd_addr  <= '0;
            fwd_data  <= '0;
        end else begin
            fwd_valid <= reg_write;
            fwd_addr  <= reg_wr_addr_wb;
            fwd_data  <= reg_wr_data;
        end
    end
endmodule

// File: doc/writeback_unit.md
# writeback_unit

Final pipeline stage of the processor. It latches MEM-stage results into the MEM/WB register, formats load data, and selects the write-back value. It drives the register-file write port of the decode stage (`reg_write`, `reg_wr_addr_wb`, `reg_wr_data`). It also supplies a one-cycle-delayed bypass copy of the last write and a retired-instruction counter.

## Interface
- `DATA_W`, default 32: datapath width.
- `REG_AW`, default 5: register address width.
- `clk` in 1: sole clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-high; clears all state immediately.
- `stall_in` in 1: hold the MEM/WB register.
- `flush_in` in 1: load a bubble into MEM/WB.
- `mem_valid` in 1: MEM stage holds a real instruction.
- `mem_reg_write` in 1: instruction writes a register.
- `mem_to_reg` in 1: write value comes from load data.
- `mem_link` in 1: write value is `mem_pc_plus8` (jal/jalr).
- `mem_rd` in REG_AW: destination register.
- `mem_alu_result` in DATA_W: ALU result; bits [1:0] are the load byte offset.
- `mem_load_data` in DATA_W: raw aligned memory word.
- `mem_pc_plus8` in DATA_W: link value.
- `mem_load_size` in 2: 00 word, 01 half, 10 byte, 11 treated as word.
- `mem_load_unsigned` in 1: zero-extend sub-word loads.
- `reg_write` out 1: register-file write enable.
- `reg_wr_addr_wb` out REG_AW: write address.
- `reg_wr_data` out DATA_W: write data.
- `fwd_valid` out 1, `fwd_addr` out REG_AW, `fwd_data` out DATA_W: copy of the previous cycle's write.
- `retired_count` out 32: instructions retired.

## Operation
- **MEM/WB register fields:** `wb_valid`, `wb_reg_write`, `wb_rd`, `wb_data`, `wb_fresh`.
- **Capture priority per edge:** reset > `flush_in` > `stall_in` > load.
  - Flush: `wb_valid`=0 and `wb_fresh`=0; other fields are don't-care.
  - Stall: all fields are held and `wb_fresh` is cleared.
  - Load: capture `mem_*`, set `wb_valid=mem_valid`, set `wb_fresh=1`.
- **Write-data select (before the register):** `mem_link` > `mem_to_reg` > ALU result. Link and load asserted together: link wins.
- **Load formatting (little-endian):**
  - Byte: select lane `mem_alu_result[1:0]`.
  - Half: lane `mem_alu_result[1]`; bit 0 is ignored, so misaligned halfwords are not trapped.
  - Sub-word results are sign-extended unless `mem_load_unsigned` is set.
- **Write port:** `reg_write = wb_valid & wb_fresh & wb_reg_write & (wb_rd != 0)`.
  - `reg_wr_addr_wb` = `wb_rd`; `reg_wr_data` = `wb_data`.
  - Writes to r0 are suppressed.
  - A stalled instruction writes exactly once, in its first WB cycle.
- **Bypass:** every non-reset edge loads `fwd_valid`/`fwd_addr`/`fwd_data` with the current `reg_write`/`reg_wr_addr_wb`/`reg_wr_data`. This is unaffected by stall and flush.
- **Retire counter:** `retired_count` increments on each load edge with `mem_valid=1`, with or without a register write. It wraps from 0xFFFF_FFFF to 0.

## Timing
- **Reset values:** all outputs are 0, `retired_count` is 0, and the internal `wb_*` fields are 0.
- **Latency:** 1 cycle from `mem_*` to the write-port outputs; 2 cycles to the `fwd_*` outputs. All outputs are registered or a single AND of registered bits.
- **Register-file write:** occurs on the edge after the write port is driven. The decode stage uses `fwd_*` to cover a same-edge read.
- **Stall and flush together:** flush wins. The held instruction is discarded, and if it was fresh its write still occurred in that cycle.
- **Back-to-back writes to the same `rd`:** each is written once, in order.
- **Reset asserted mid-stall:** state clears immediately. The counter does not count the discarded instruction.

## Configuration
- `WB_LOAD_FORMAT_EN` defined: sub-word extraction and extension as described under Operation.
- `WB_LOAD_FORMAT_EN` undefined: `mem_load_size`, `mem_load_unsigned` and the offset bits are ignored, and load data is written as the full word.

## Structure
- **Shared package `cpu_pkg`:**
  - `DATA_W` and `REG_AW` defaults.
  - Load-size constants `LS_WORD`=2'b00, `LS_HALF`=2'b01, `LS_BYTE`=2'b10.
  - `REG_ZERO`=5'd0.
- **Sub-module `load_formatter`:** combinational (data, offset, size, unsigned → formatted word). It is instantiated only under `WB_LOAD_FORMAT_EN`.

## Test plan
- **ALU write:** load `mem_valid=1`, `reg_write=1`, rd=5, alu=0x1234 → next cycle `reg_write=1`, addr 5, data 0x1234. One cycle later `fwd_valid=1`, `fwd_addr=5`. `retired_count=1`.
- **r0 suppression:** rd=0, reg_write=1 → `reg_write=0`, `retired_count` still increments.
- **Load formatting:** load word 0x80FF7F01.
  - Byte, offset 1, signed → 0x0000007F.
  - Byte, offset 2, signed → 0xFFFFFFFF.
  - Half, offset 2, unsigned → 0x000080FF.
  - With the macro undefined, every case → 0x80FF7F01.
- **Link priority:** `mem_link=1` and `mem_to_reg=1`, pc_plus8=0x400008 → data 0x400008.
- **Stall for 3 cycles after capture:** `reg_write` high 1 cycle, then low while the outputs are held. `retired_count` is unchanged during the stall. Stall and flush in the same cycle → `wb_valid=0`.
- **Asynchronous reset mid-operation:** assert `reset` between edges → all outputs 0 immediately. Counter at 0xFFFFFFFF plus one retire → 0.
